// File: rtl/neuron_sequencer.sv
// Sequencer for one sigmoid-ALU neuron evaluation: clears the accumulator, streams
// weight/input groups from SRAM, aligns accumulate to the ALU pipeline and captures the result.
module neuron_sequencer #(
    parameter int unsigned N_INPUTS = 64,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        bias_in,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              alu_clear,
    output logic              alu_accumulate,
    output logic [3:0]        alu_bias,
    input  logic [4:0]        alu_out,
    output logic              busy,
    output logic              done,
    output logic [4:0]        result
);

    localparam int unsigned G  = N_INPUTS / 4;
    localparam int unsigned CW = (G > 1) ? $clog2(G) : 1;
    localparam logic [CW-1:0] LastGrp = CW'(G - 1);

    typedef enum logic [2:0] {StIdle, StClear, StFetch, StDrain, StDone} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        drain_cnt;
    logic [ADDR_W-1:0] base_q;
    logic              p0, p1;

    // Read at t, lane data at t+1, product register loads end of t+1, accumulate at t+2.
    assign alu_accumulate = p1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= StIdle;
            cnt       <= '0;
            drain_cnt <= '0;
            base_q    <= '0;
            p0        <= 1'b0;
            p1        <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            alu_clear <= 1'b0;
            alu_bias  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            p0 <= mem_re;
            p1 <= p0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        base_q    <= base_addr;
                        alu_bias  <= bias_in;
                        cnt       <= '0;
                        alu_clear <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StClear;
                    end
                end
                StClear: begin
                    alu_clear <= 1'b0;
                    mem_re    <= 1'b1;
                    mem_addr  <= base_q;
                    state     <= StFetch;
                end
                StFetch: begin
                    if (cnt == LastGrp) begin
                        mem_re    <= 1'b0;
                        mem_addr  <= '0;
                        drain_cnt <= '0;
                        state     <= StDrain;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                StDrain: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd2) begin
                        result <= alu_out;
                        done   <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a behavioural SRAM + sigmoid-ALU stand-in
// (uniform weight/input words, 4 lanes, product register, accumulator, clamped sigmoid).
module tb_neuron_sequencer;

    localparam int unsigned N_INPUTS = 16;
    localparam int unsigned ADDR_W   = 8;
    localparam int G = N_INPUTS / 4;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [3:0]        bias_in = '0;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic              alu_clear;
    logic              alu_accumulate;
    logic [3:0]        alu_bias;
    logic [4:0]        alu_out;
    logic              busy;
    logic              done;
    logic [4:0]        result;

    int checks = 0;
    int errors = 0;

    neuron_sequencer #(.N_INPUTS(N_INPUTS), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .base_addr      (base_addr),
        .bias_in        (bias_in),
        .mem_re         (mem_re),
        .mem_addr       (mem_addr),
        .alu_clear      (alu_clear),
        .alu_accumulate (alu_accumulate),
        .alu_bias       (alu_bias),
        .alu_out        (alu_out),
        .busy           (busy),
        .done           (done),
        .result         (result)
    );

    always #5 clk = ~clk;

    // Environment model: every SRAM word holds w_val (weights) / x_val (inputs) in all lanes.
    int w_val = 0;
    int x_val = 0;
    int rd_w = 0, rd_x = 0, prod = 0, acc = 0;
    int s, v;

    always @(posedge clk) begin
        if (mem_re) begin
            rd_w <= w_val;
            rd_x <= x_val;
        end
        prod <= 4 * rd_w * rd_x;
        if (alu_clear) acc <= 0;
        else if (alu_accumulate) acc <= acc + prod;
    end

    always_comb begin
        s = acc + int'($signed(alu_bias));
        v = (s >>> 2) + 4;
        if (v < 0) v = 0;
        if (v > 7) v = 7;
        alu_out = 5'(v);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start accepted in cycle 0; checks every output in cycles 1..G+6.
    task automatic run(input int base, input int bias, input int w, input int x, input int exp_res);
        int prev;
        prev = int'(result);
        w_val = w;
        x_val = x;
        base_addr = ADDR_W'(base);
        bias_in = 4'(bias);
        start = 1'b1;
        for (int c = 1; c <= G + 6; c++) begin
            tick();
            start = 1'b0;
            base_addr = '0;
            bias_in = '0;
            check("clear", int'(alu_clear), int'(c == 1));
            check("mem_re", int'(mem_re), int'(c >= 2 && c <= G + 1));
            check("mem_addr", int'(mem_addr), (c >= 2 && c <= G + 1) ? (base + c - 2) % 256 : 0);
            check("accumulate", int'(alu_accumulate), int'(c >= 4 && c <= G + 3));
            check("busy", int'(busy), int'(c <= G + 5));
            check("done", int'(done), int'(c == G + 5));
            check("result", int'(result), (c == G + 5 || c == G + 6) ? exp_res : prev);
            if (c == 1) check("alu_bias", int'(alu_bias), bias & 15);
        end
    endtask

    int dcount;

    initial begin
        // Reset values
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_outs", int'({mem_re, mem_addr, alu_clear, alu_accumulate, alu_bias, done, result}), 0);
        tick();
        n_rst = 1'b1;
        tick();
        check("idle_busy", int'(busy), 0);

        // Basic sum: 16 * (+1 * +1) -> 7
        run(16, 0, 1, 1, 7);
        check("accum_final", acc, 16);
        run(40, 0, -8, 15, 0);
        run(3, 0, 0, 0, 4);
        run(254, 0, 1, 1, 7);
        run(100, -4, 0, 0, 3);

        // Start pulsed in cycles 3 and G+5: exactly one done, idle afterwards
        w_val = 1; x_val = 1;
        dcount = 0;
        start = 1'b1;
        for (int c = 1; c <= G + 10; c++) begin
            tick();
            start = (c == 3 || c == G + 5);
            if (done) dcount++;
            if (c == G + 6) check("pulse_idle", int'(busy), 0);
        end
        start = 1'b0;
        check("pulse_dones", dcount, 1);

        // Start held high: second CLEAR in cycle G+7
        start = 1'b1;
        for (int c = 1; c <= G + 8; c++) begin
            tick();
            check("held_clear", int'(alu_clear), int'(c == 1 || c == G + 7));
            check("held_done", int'(done), int'(c == G + 5));
        end
        start = 1'b0;
        for (int c = 0; c < 3 * G + 20 && busy; c++) tick();
        check("held_finish", int'(busy), 0);

        // Asynchronous reset mid-FETCH
        w_val = 1; x_val = 1;
        base_addr = 8'd10;
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            start = 1'b0;
        end
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_outs", int'({mem_re, mem_addr, alu_clear, alu_accumulate, alu_bias, done, result}), 0);
        tick();
        n_rst = 1'b1;
        dcount = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done) dcount++;
        end
        check("midrst_nodone", dcount, 0);
        check("midrst_idle", int'({busy, mem_re}), 0);
        run(20, 0, 0, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_sequencer.md
# neuron_sequencer

Controller that sequences one sigmoid-ALU neuron evaluation. It zeroes the accumulator and streams the neuron's weight/input words out of memory four lanes at a time. It times `accumulate` against the ALU's internal pipeline register, then captures the sigmoid output once the final sum has settled. It sits between the layer-level control FSM (start/done handshake) and the sigmoid ALU plus its weight/input SRAMs.

## Interface
- `N_INPUTS`, default 64: number of inputs per neuron. Must be a multiple of 4 and at least 4. G = N_INPUTS/4 groups.
- `ADDR_W`, default 8: width of the memory group address.
- `clk`  in  1: single clock. Every register updates on the rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: request one neuron evaluation. Sampled only in IDLE.
- `base_addr`  in  ADDR_W: group address of the neuron's first weight/input word. Latched on accepted start.
- `bias_in`  in  4: neuron bias, signed s3.0. Latched on accepted start.
- `mem_re`  out  1: read strobe to the weight and input SRAMs. Read data reaches the ALU lanes one cycle later.
- `mem_addr`  out  ADDR_W: group address, equal to base + group count, modulo 2^ADDR_W.
- `alu_clear`  out  1: drives ALU `clear`.
- `alu_accumulate`  out  1: drives ALU `accumulate`.
- `alu_bias`  out  4: drives ALU `bias`. Holds the latched bias.
- `alu_out`  in  5: ALU sigmoid output.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse when `result` is updated.
- `result`  out  5: captured sigmoid value. Held until the next capture.

## Operation
- States: IDLE → CLEAR → FETCH → DRAIN → DONE → IDLE.
- **IDLE**
  - Wait for `start`.
  - On `start`=1: latch `base_addr` and `bias_in`, zero the group counter, go to CLEAR.
- **CLEAR** (1 cycle)
  - `alu_clear`=1, `mem_re`=0.
  - The accumulator reads zero from the next cycle.
- **FETCH** (exactly G cycles)
  - `mem_re`=1 and `mem_addr`=base+cnt; cnt increments every cycle.
  - After the cycle with cnt=G−1, go to DRAIN.
- **Accumulate pipeline**
  - 2-stage shift register: p0 ← `mem_re`, p1 ← p0, `alu_accumulate` = p1.
  - Rationale: read at cycle t, lane data valid at t+1, ALU product register loads at the end of t+1, accumulator adds during t+2.
  - `alu_accumulate` is high for exactly G cycles per run and never overlaps `alu_clear`.
- **DRAIN** (3 cycles, internal counter)
  - Cycles 1–2: the last two groups are accumulated by the pipeline.
  - Cycle 3: `alu_accumulate`=0, the accumulator is final and `alu_out` is settled. `result` ← `alu_out` at the end of this cycle.
- **DONE** (1 cycle)
  - `done`=1, `result` is valid, `busy`=1.
  - Next state is IDLE unconditionally.
  - `start` in DONE is ignored; it is sampled again in IDLE.
- `start` in any non-IDLE state is ignored. No queuing, no restart.
- `mem_addr` is 0 and `mem_re` is 0 outside FETCH.
- Arithmetic: `mem_addr` is an unsigned ADDR_W-bit add that wraps modulo 2^ADDR_W. The block performs no other arithmetic.

## Timing
- **Reset values**: IDLE; `mem_re`, `mem_addr`, `alu_clear`, `alu_accumulate`, `alu_bias`, `busy`, `done` and `result` are all 0; p0, p1 and the counters are 0.
- **Reset mid-run**: return immediately to IDLE with all outputs at reset values. No `done` is issued. The ALU accumulator is left stale, which is harmless because the next run begins with CLEAR.
- **Latency**: with `start` accepted in cycle 0, the schedule is:
  - cycle 1: CLEAR
  - cycles 2..G+1: FETCH
  - cycles G+2..G+4: DRAIN
  - cycle G+5: `done`=1
- `busy` rises in cycle 1 and falls after cycle G+5.
- Back-to-back runs: `start` high in cycle G+6 (IDLE) is accepted. Minimum period is G+6 cycles.
- `done` is never asserted for two consecutive cycles.
- `result` changes only at the end of DRAIN cycle 3.

## Test plan
- **Reset**: drive `n_rst`=0 asynchronously mid-cycle → every output is 0 immediately; after release, `busy`=0 and `mem_re`=0.
- **Basic sum** (N_INPUTS=16, G=4): all weights +1, inputs +1, bias 0, `start` at cycle 0.
  - `mem_re` high in cycles 2–5 with addresses base..base+3.
  - `alu_accumulate` high in cycles 4–7; `accum_out`=16.
  - `done` in cycle 9 with `result`=7.
- **Negative saturation**: weights −8, inputs 15, bias 0 → `result`=0. With weights 0 and bias 0 → `result`=4.
- **Ignored start**: `start` pulsed in cycles 3 and 9 → single `done` in cycle 9. `start` held high continuously → next CLEAR in cycle 11.
- **Reset mid-FETCH**: `n_rst` low in cycle 3 → no `done`. A following run returns the correct `result`, unaffected by the stale accumulator.
- **Address wrap** (ADDR_W=8): `base_addr`=254 with G=4 → `mem_addr` sequence 254, 255, 0, 1.
